// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus: initiator FSM states and the
// default bus geometry used by Timer16 and later responders.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } bus_init_state_t;

  localparam int unsigned PERIPH_ADDR_W = 2;
  localparam int unsigned PERIPH_DATA_W = 16;
  localparam int unsigned WAIT_W        = 4;

endpackage

// File: rtl/periph_bus_initiator.sv
// Initiator end of the peripheral bus (busAddr/busData/busEn/busWr).
// Accepts a valid/ready request, holds busEn for WAIT_CYCLES+1 cycles,
// inserts a released turnaround cycle (DONE) that also carries rspValid.
// Optional macro PERIPH_BUS_INITIATOR_B2B_EN: accept a new request in DONE.
module periph_bus_initiator
  import periph_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = PERIPH_ADDR_W,
  parameter int unsigned DATA_W      = PERIPH_DATA_W,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWr,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              rspValid,
  output logic              rspWr,
  output logic [DATA_W-1:0] rspData,
  output logic [ADDR_W-1:0] busAddr,
  inout  wire  [DATA_W-1:0] busData,
  output logic              busEn,
  output logic              busWr
);

  bus_init_state_t   state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_wr_q, rsp_wr_d;

  logic              req_ready;
  logic              bus_en;
  logic              rsp_valid;

  // Next-state, request latch, wait counter and read-data capture
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_wr_d   = rsp_wr_q;
    req_ready  = 1'b0;
    bus_en     = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      ACCESS: begin
        bus_en = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          state_d  = DONE;
          rsp_wr_d = wr_q;
          if (!wr_q) begin
            rsp_data_d = busData;
          end
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
`ifdef PERIPH_BUS_INITIATOR_B2B_EN
        req_ready = 1'b1;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance shared by IDLE and (optionally) DONE; overrides the
    // state chosen above so DONE can chain straight into ACCESS.
    if (req_ready && reqValid) begin
      wr_d    = reqWr;
      addr_d  = reqAddr;
      data_d  = reqData;
      cnt_d   = WAIT_W'(WAIT_CYCLES);
      state_d = ACCESS;
    end
  end

  // State and datapath registers; reset drops any access in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_wr_q   <= rsp_wr_d;
    end
  end

  assign reqReady = req_ready;
  assign rspValid = rsp_valid;
  assign rspWr    = rsp_wr_q;
  assign rspData  = rsp_data_q;
  assign busAddr  = addr_q;
  assign busEn    = bus_en;
  assign busWr    = bus_en & wr_q;

  // Drive the shared data lines only during a write access
  assign busData  = (bus_en && wr_q) ? data_q : 'z;

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Scoreboard bench for periph_bus_initiator with a 4-register responder.
// Build with +define+PERIPH_BUS_INITIATOR_B2B_EN to check the chained mode.
module tb_periph_bus_initiator;

  localparam int unsigned AW   = 2;
  localparam int unsigned DW   = 16;
  localparam int unsigned WAIT = 2;
`ifdef PERIPH_BUS_INITIATOR_B2B_EN
  localparam int unsigned PERIOD = WAIT + 2;
`else
  localparam int unsigned PERIOD = WAIT + 3;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqWr = 1'b0;
  logic [AW-1:0] reqAddr = '0;
  logic [DW-1:0] reqData = '0;
  logic          reqReady;
  logic          rspValid;
  logic          rspWr;
  logic [DW-1:0] rspData;
  logic [AW-1:0] busAddr;
  logic          busEn;
  logic          busWr;
  wire  [DW-1:0] bus_data;

  periph_bus_initiator #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWr    (reqWr),
    .reqAddr  (reqAddr),
    .reqData  (reqData),
    .rspValid (rspValid),
    .rspWr    (rspWr),
    .rspData  (rspData),
    .busAddr  (busAddr),
    .busData  (bus_data),
    .busEn    (busEn),
    .busWr    (busWr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: register file driven onto the bus during reads
  logic [DW-1:0] resp_regs [4];
  assign bus_data = (busEn && !busWr) ? resp_regs[busAddr] : 'z;
  always @(posedge clk) if (busEn && busWr) resp_regs[busAddr] <= bus_data;

  typedef struct {
    int unsigned   e;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t          rspq[$];
  txn_t          cur;
  bit            active = 0;
  int unsigned   next_free = 0;
  logic [DW-1:0] last_rd = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] exp_regs [4];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and monitor: predicts handshake and bus timing per cycle,
  // pushes each accepted request, pops when the DUT presents rspValid.
  always @(negedge clk) begin
    int unsigned c;
    bit exp_ready, in_acc, in_done;
    txn_t t;
    if (!rstn) begin
      rspq.delete();
      active    = 0;
      next_free = 0;
      last_rd   = '0;
      last_addr = '0;
      chk("rst_busEn", busEn, 0);
      chk("rst_rspValid", rspValid, 0);
      chk("rst_reqReady", reqReady, 1);
      chk("rst_rspData", rspData, 0);
      chk("rst_rspWr", rspWr, 0);
      chk("rst_busAddr", busAddr, 0);
    end else begin
      c         = cyc;
      exp_ready = (c + 1 >= next_free);
      in_acc    = active && c >= cur.e && c <= cur.e + WAIT;
      in_done   = active && c == cur.e + WAIT + 1;
      chk("reqReady", reqReady, exp_ready);
      chk("busEn", busEn, in_acc);
      chk("busWr", busWr, in_acc && cur.wr);
      chk("rspValid", rspValid, in_done);
      chk("busAddr", busAddr, last_addr);
      if (in_acc) chk("busData", bus_data, cur.wr ? cur.data : cur.rd);
      if (rspValid) begin
        if (rspq.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          t = rspq.pop_front();
          chk("rsp_latency", c, t.e + WAIT + 1);
          chk("rspWr", rspWr, t.wr);
          if (!t.wr) last_rd = t.rd;
        end
      end
      chk("rspData", rspData, last_rd);
      if (reqValid && exp_ready) begin
        t.e  = c + 1;
        t.wr = reqWr;
        t.addr = reqAddr;
        t.data = reqData;
        t.rd = exp_regs[reqAddr];
        if (reqWr) exp_regs[reqAddr] = reqData;
        cur       = t;
        active    = 1;
        next_free = t.e + PERIOD;
        last_addr = reqAddr;
        rspq.push_back(t);
      end
    end
  end

  // Present one request and hold it until the accept edge has passed
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n;
    reqValid = 1'b1;
    reqWr    = wr;
    reqAddr  = a;
    reqData  = d;
    n = 0;
    @(negedge clk);
    while (!reqReady && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!reqReady) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqData  = ~d;
  endtask

  task automatic drain();
    reqValid = 1'b0;
    repeat (PERIOD + 4) @(posedge clk);
    #1;
  endtask

  task automatic rand_phase(input int unsigned n, input bit hold);
    repeat (n) begin
      @(posedge clk);
      #1;
      reqValid = hold ? 1'b1 : ($urandom_range(0, 9) < 4);
      reqWr    = 1'($urandom);
      reqAddr  = AW'($urandom);
      reqData  = DW'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      resp_regs[i] = DW'($urandom);
      exp_regs[i]  = resp_regs[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b1, 2'd1, 16'h0021);
    issue(1'b1, 2'd2, 16'hBEEF);
    issue(1'b0, 2'd2, 16'h0000);
    issue(1'b1, 2'd3, 16'h1234);
    issue(1'b0, 2'd1, 16'h0000);
    drain();

    rand_phase(400, 1'b0);
    rand_phase(40, 1'b1);
    drain();

    issue(1'b0, 2'd3, 16'h0000);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_busEn", busEn, 0);
    chk("async_rspValid", rspValid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;

    rand_phase(150, 1'b0);
    drain();
    chk("queue_empty", rspq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
